// File: rtl/alt_xcvr_reconfig_cpu_debug_cmd_sysclk.sv
// CPU debug slave, system-clock side: resyncs TCK-domain toggle events,
// latches IR/data and issues one-hot action pulses with ready/overrun/ack.
module alt_xcvr_reconfig_cpu_debug_cmd_sysclk #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 34,
  localparam int NUM_CMD    = 2**IR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vs_uir_tgl,
  input  logic                vs_e1dr_tgl,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [SR_WIDTH-1:0] sr,
  input  logic                cmd_ready,
  input  logic                overrun_clr,
  output logic [IR_WIDTH-1:0] ir_q,
  output logic [SR_WIDTH-1:0] jdo,
  output logic [NUM_CMD-1:0]  take_action,
  output logic [NUM_CMD-1:0]  take_no_action,
  output logic                cmd_pending,
  output logic                overrun,
  output logic                ack_tgl
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  localparam logic [2:0] GUARD_INIT = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] uir_s;
  logic [SYNC_STAGES-1:0] e1dr_s;
  logic                   uir_p;
  logic                   e1dr_p;
  logic [2:0]             guard;
  logic                   armed;
  logic                   uir_ev;
  logic                   e1dr_ev;

  logic [0:0]             state;
  logic [0:0]             state_nxt;
  logic [IR_WIDTH-1:0]    code;
  logic [IR_WIDTH-1:0]    cur_code;
  logic [NUM_CMD-1:0]     code_oh;
  logic                   accept;
  logic                   ovr_ev;
  logic                   dlv_set;
  logic                   dlv;

  always_ff @(posedge clk) begin
    if (reset) begin
      uir_s  <= '0;
      e1dr_s <= '0;
      uir_p  <= 1'b0;
      e1dr_p <= 1'b0;
      guard  <= GUARD_INIT;
    end else begin
      uir_s  <= {uir_s[SYNC_STAGES-2:0], vs_uir_tgl};
      e1dr_s <= {e1dr_s[SYNC_STAGES-2:0], vs_e1dr_tgl};
      uir_p  <= uir_s[SYNC_STAGES-1];
      e1dr_p <= e1dr_s[SYNC_STAGES-1];
      if (guard != 3'd0) guard <= guard - 3'd1;
    end
  end

  // p keeps tracking while masked so a level held over reset never fires
  assign armed   = (guard == 3'd0);
  assign uir_ev  = armed & (uir_s[SYNC_STAGES-1] ^ uir_p);
  assign e1dr_ev = armed & (e1dr_s[SYNC_STAGES-1] ^ e1dr_p);

  assign cur_code = uir_ev ? ir_in : ir_q;
  assign code_oh  = NUM_CMD'(1) << code;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ovr_ev    = 1'b0;
    dlv_set   = 1'b0;
    unique case (state)
      IDLE: begin
        accept  = e1dr_ev;
        dlv_set = e1dr_ev & cmd_ready;
        if (e1dr_ev && !cmd_ready) state_nxt = PEND;
      end
      PEND: begin
        ovr_ev  = e1dr_ev;
        dlv_set = cmd_ready;
        if (cmd_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_pending = (state == PEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ir_q           <= '0;
      jdo            <= '0;
      code           <= '0;
      dlv            <= 1'b0;
      take_action    <= '0;
      take_no_action <= '0;
      overrun        <= 1'b0;
      ack_tgl        <= 1'b0;
    end else begin
      state <= state_nxt;
      dlv   <= dlv_set;
      if (uir_ev) ir_q <= ir_in;
      if (accept) begin
        jdo  <= sr;
        code <= cur_code;
      end
      take_action    <= (dlv && jdo[ACT_BIT]) ? code_oh : '0;
      take_no_action <= (dlv && !jdo[ACT_BIT]) ? code_oh : '0;
      // dropped commands still ack so the TCK side never stalls
      ack_tgl <= ack_tgl ^ dlv ^ ovr_ev;
      if (ovr_ev) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule
